// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port unified program/data memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to r0.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_command
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic              we_q, we_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
    logic              r0_ack_q, r0_ack_d;
    logic              r1_ack_q, r1_ack_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic              any_req;
    logic              winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`endif

    assign any_req = r0_req | r1_req;

    // Winner is only meaningful in StIdle with any_req set.
    always_comb begin
        winner = ~r0_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (r0_req && r1_req) begin
            winner = ~last_q;
        end
`endif
    end

    assign sel_we    = winner ? r1_we    : r0_we;
    assign sel_addr  = winner ? r1_addr  : r0_addr;
    assign sel_wdata = winner ? r1_wdata : r0_wdata;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        r0_rdata_d  = r0_rdata_q;
        r1_rdata_d  = r1_rdata_q;
        r0_ack_d    = 1'b0;
        r1_ack_d    = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d     = winner;
                    we_d        = sel_we;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    // Strobes rise together with the new address on this edge.
                    mem_read_d  = ~sel_we;
                    mem_write_d = sel_we;
                    state_d     = StAccess;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d      = winner;
`endif
                end
            end
            StAccess: begin
                // Memory read data has settled by the end of the strobe cycle.
                if (!we_q) begin
                    if (grant_q) begin
                        r1_rdata_d = mem_command;
                    end else begin
                        r0_rdata_d = mem_command;
                    end
                end
                r0_ack_d = ~grant_q;
                r1_ack_d = grant_q;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            grant_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
            r0_ack_q    <= 1'b0;
            r1_ack_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            r0_rdata_q  <= r0_rdata_d;
            r1_rdata_q  <= r1_rdata_d;
            r0_ack_q    <= r0_ack_d;
            r1_ack_q    <= r1_ack_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    assign r0_ack         = r0_ack_q;
    assign r1_ack         = r1_ack_q;
    assign r0_rdata       = r0_rdata_q;
    assign r1_rdata       = r1_rdata_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;

    ack_onehot_a : assert property (@(posedge clk) disable iff (rst) !(r0_ack && r1_ack));
    strobe_excl_a : assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected acks, a negedge monitor checks them.
// Tie expectations follow MEM_ARB_ROUND_ROBIN_EN as the DUT does.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [12:0] r0_addr = '0;
    logic [7:0]  r0_wdata = '0;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [12:0] r1_addr = '0;
    logic [7:0]  r1_wdata = '0;
    logic        r0_ack, r1_ack, mem_read, mem_write;
    logic [7:0]  r0_rdata, r1_rdata, mem_write_data, mem_command;
    logic [12:0] mem_address;

    mem_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .r0_req         (r0_req),
        .r0_we          (r0_we),
        .r0_addr        (r0_addr),
        .r0_wdata       (r0_wdata),
        .r0_ack         (r0_ack),
        .r0_rdata       (r0_rdata),
        .r1_req         (r1_req),
        .r1_we          (r1_we),
        .r1_addr        (r1_addr),
        .r1_wdata       (r1_wdata),
        .r1_ack         (r1_ack),
        .r1_rdata       (r1_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_command    (mem_command)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model with preload.
    logic [7:0] tb_mem [0:8191];
    bit mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) tb_mem[i] <= 8'h00;
            tb_mem[1000] <= 8'd5;
            tb_mem[1001] <= 8'd130;
            tb_mem[1002] <= 8'd126;
            tb_mem[1003] <= 8'd54;
            mem_ready <= 1'b1;
        end else if (mem_write) begin
            tb_mem[mem_address] <= mem_write_data;
        end
    end
    assign mem_command = tb_mem[mem_address];

    typedef struct {
        bit          id;
        bit          we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  data;
        int          at;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit id, input logic req, input logic we,
                         input logic [12:0] addr, input logic [7:0] wdata);
        if (id) begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
        end else begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
        end
    endtask

    task automatic push(input bit id, input bit we, input logic [12:0] addr,
                        input logic [7:0] wdata, input logic [7:0] data, input int at);
        exp_t e;
        e.id = id; e.we = we; e.addr = addr; e.wdata = wdata; e.data = data; e.at = at;
        sb.push_back(e);
    endtask

    // Single access; rd is the rdata expected with ack (unchanged value for writes).
    task automatic access(input bit id, input bit we, input logic [12:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rd);
        drive(id, 1'b1, we, addr, wdata);
        push(id, we, addr, wdata, rd, cyc + 2);
        @(posedge clk); #1;
        drive(id, 1'b1, ~we, ~addr, ~wdata);  // post-grant changes must be ignored
        repeat (2) @(posedge clk);
        #1;
        drive(id, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
    endtask

    // Monitor.
    logic        prev_read = 1'b0, prev_write = 1'b0, prev_rst = 1'b1;
    logic [12:0] prev_addr = '0;
    logic [7:0]  prev_wdata = '0;
    always @(negedge clk) begin
        exp_t e;
        if (r0_ack || r1_ack) begin
            chk("ack_onehot", 32'(r0_ack) + 32'(r1_ack), 1);
            if (sb.size() == 0) begin
                chk("ack_expected", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("ack_id", r1_ack, e.id);
                chk("ack_cycle", cyc, e.at);
                chk("rdata", r1_ack ? r1_rdata : r0_rdata, e.data);
                chk("strobe_kind", {prev_write, prev_read}, {e.we, !e.we});
                chk("strobe_addr", prev_addr, e.addr);
                if (e.we) chk("strobe_wdata", prev_wdata, e.wdata);
            end
        end
        if (!prev_rst && (prev_read || prev_write)) begin
            chk("addr_hold", mem_address, prev_addr);
            chk("wdata_hold", mem_write_data, prev_wdata);
            chk("strobe_pulse", {mem_read, mem_write}, 0);
        end
        prev_read  <= mem_read;
        prev_write <= mem_write;
        prev_addr  <= mem_address;
        prev_wdata <= mem_write_data;
        prev_rst   <= rst;
    end

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_mem_read"}, mem_read, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_r0_ack"}, r0_ack, 0);
        chk({tag, "_r1_ack"}, r1_ack, 0);
        chk({tag, "_r0_rdata"}, r0_rdata, 0);
        chk({tag, "_r1_rdata"}, r1_rdata, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_write_data"}, mem_write_data, 0);
    endtask

    logic [7:0] b2b_exp [0:3];
    int t0;

    initial begin
        b2b_exp[0] = 8'd5; b2b_exp[1] = 8'd130; b2b_exp[2] = 8'd126; b2b_exp[3] = 8'd54;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reads and writes from each requester.
        access(1'b0, 1'b0, 13'd1000, 8'h00, 8'd5);
        access(1'b1, 1'b1, 13'd2000, 8'hAA, 8'd0);
        access(1'b1, 1'b0, 13'd2000, 8'h00, 8'hAA);

        // Back-to-back r0 reads, req held throughout.
        r0_req = 1'b1; r0_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            r0_addr = 13'(1000 + k);
            push(1'b0, 1'b0, r0_addr, 8'h00, b2b_exp[k], cyc + 2);
            repeat (3) @(posedge clk);
            #1;
        end
        r0_req = 1'b0;
        @(posedge clk); #1;

        // Reset during ACCESS of a read: no ack, everything cleared.
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 13'd1000;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        r0_req = 1'b0;
        @(negedge clk);
        chk_idle_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 13'd1000, 8'h00, 8'd5);

        // Tie with both requests held for four accesses.
        r0_we = 1'b0; r0_addr = 13'd1001;
        r1_we = 1'b0; r1_addr = 13'd1002;
        r0_req = 1'b1; r1_req = 1'b1;
        t0 = cyc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push(1'b0, 1'b0, 13'd1001, 8'h00, 8'd130, t0 + 2);
        push(1'b1, 1'b0, 13'd1002, 8'h00, 8'd126, t0 + 5);
        push(1'b0, 1'b0, 13'd1001, 8'h00, 8'd130, t0 + 8);
        push(1'b1, 1'b0, 13'd1002, 8'h00, 8'd126, t0 + 11);
`else
        for (int k = 0; k < 4; k++) push(1'b0, 1'b0, 13'd1001, 8'h00, 8'd130, t0 + 2 + 3 * k);
`endif
        repeat (12) @(posedge clk);
        #1;
        r0_req = 1'b0; r1_req = 1'b0;

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("pending_acks", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
